// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state and datapath-select encodings for shift_seq_ctrl
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_TX_SHIFT = 2'b01,
        ST_RX_SHIFT = 2'b10,
        ST_RX_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD = 2'b00,
        SEL_SHR  = 2'b01,
        SEL_SHL  = 2'b10,
        SEL_LOAD = 2'b11
    } dp_sel_e;

endpackage

// File: rtl/shift_seq_dp.sv
// rtl/shift_seq_dp.sv - N-bit shift/load register driven by the shift_seq_ctrl FSM
module shift_seq_dp
    import shift_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  dp_sel_e      select,
    input  logic         msb_in,
    input  logic         lsb_in,
    input  logic [N-1:0] p_in,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            case (select)
                SEL_SHR:  q <= {msb_in, q[N-1:1]};
                SEL_SHL:  q <= {q[N-2:0], lsb_in};
                SEL_LOAD: q <= p_in;
                default:  q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - serializer/deserializer sequencer; RX path built only with SHIFT_SEQ_RX_EN
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tx_valid,
    input  logic [N-1:0] tx_data,
    output logic         tx_ready,
    input  logic         msb_first,
    output logic         ser_out,
    output logic         ser_out_valid,
    input  logic         rx_start,
    input  logic         ser_in,
    output logic         rx_valid,
    output logic [N-1:0] rx_data,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state;
    logic [CW-1:0]   cnt;
    logic            msb_q;
    dp_sel_e         sel;
    logic            dp_msb_in;
    logic            dp_lsb_in;
    logic [N-1:0]    q;
    logic            tx_hs;

    // tx_ready is a registered "in IDLE and out of reset" flag, so it doubles as the idle qualifier
    assign tx_hs   = tx_valid & tx_ready;
    assign ser_out = ser_out_valid & (msb_q ? q[N-1] : q[0]);

    always_comb begin
        sel       = SEL_HOLD;
        dp_msb_in = 1'b0;
        dp_lsb_in = 1'b0;
        case (state)
            ST_IDLE:     if (tx_hs) sel = SEL_LOAD;
            ST_TX_SHIFT: sel = msb_q ? SEL_SHL : SEL_SHR;
            ST_RX_SHIFT: begin
                sel       = msb_q ? SEL_SHL : SEL_SHR;
                dp_msb_in = ser_in;
                dp_lsb_in = ser_in;
            end
            default:     sel = SEL_HOLD;
        endcase
    end

    shift_seq_dp #(.N(N)) u_dp (
        .clk     (clk),
        .reset_n (reset_n),
        .select  (sel),
        .msb_in  (dp_msb_in),
        .lsb_in  (dp_lsb_in),
        .p_in    (tx_data),
        .q       (q)
    );

`ifdef SHIFT_SEQ_RX_EN
    logic         rx_go;
    logic         rx_valid_q;
    logic [N-1:0] rx_data_q;
    logic [N-1:0] rx_next;

    assign rx_go    = tx_ready & rx_start & ~tx_valid;
    assign rx_next  = msb_q ? {q[N-2:0], ser_in} : {ser_in, q[N-1:1]};
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
`else
    logic unused_rx;
    assign unused_rx = ^{rx_start, q};
    assign rx_valid  = 1'b0;
    assign rx_data   = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            msb_q         <= 1'b0;
            tx_ready      <= 1'b0;
            ser_out_valid <= 1'b0;
            busy          <= 1'b0;
`ifdef SHIFT_SEQ_RX_EN
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
`endif
        end else begin
`ifdef SHIFT_SEQ_RX_EN
            rx_valid_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    tx_ready <= 1'b1;
                    if (tx_hs) begin
                        state         <= ST_TX_SHIFT;
                        cnt           <= '0;
                        msb_q         <= msb_first;
                        tx_ready      <= 1'b0;
                        ser_out_valid <= 1'b1;
                        busy          <= 1'b1;
                    end
`ifdef SHIFT_SEQ_RX_EN
                    else if (rx_go) begin
                        state    <= ST_RX_SHIFT;
                        cnt      <= '0;
                        msb_q    <= msb_first;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
`endif
                end
                ST_TX_SHIFT: begin
                    if (cnt == LAST) begin
                        state         <= ST_IDLE;
                        ser_out_valid <= 1'b0;
                        tx_ready      <= 1'b1;
                        busy          <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SHIFT_SEQ_RX_EN
                ST_RX_SHIFT: begin
                    if (cnt == LAST) begin
                        state      <= ST_RX_DONE;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RX_DONE: begin
                    state    <= ST_IDLE;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                end
`endif
                default: begin
                    state         <= ST_IDLE;
                    ser_out_valid <= 1'b0;
                    tx_ready      <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl (N=4)
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [3:0] tx_data = 4'd0;
    logic       tx_ready;
    logic       msb_first = 1'b0;
    logic       ser_out;
    logic       ser_out_valid;
    logic       rx_start = 1'b0;
    logic       ser_in = 1'b0;
    logic       rx_valid;
    logic [3:0] rx_data;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.N(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .msb_first     (msb_first),
        .ser_out       (ser_out),
        .ser_out_valid (ser_out_valid),
        .rx_start      (rx_start),
        .ser_in        (ser_in),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .busy          (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({tx_ready, busy, ser_out_valid, ser_out, rx_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 00000", {tx_ready, busy, ser_out_valid, ser_out, rx_valid});
        end
        checks++;
        if (rx_data !== 4'b0000) begin
            failures++;
            $display("FAIL reset_rx_data: got %b expected 0000", rx_data);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if ({tx_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: tx_ready,busy got %b expected 10", {tx_ready, busy});
        end
    endtask

    task automatic test_tx_lsb_first();
        logic [3:0] seq;
        seq = 4'b1011;
        tx_data = 4'b1011;
        msb_first = 1'b0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ser_out_valid, ser_out, tx_ready, busy} !== {1'b1, seq[i], 1'b0, 1'b1}) begin
                failures++;
                $display("FAIL tx_lsb_bit%0d: valid,out,ready,busy got %b expected %b", i,
                         {ser_out_valid, ser_out, tx_ready, busy}, {1'b1, seq[i], 1'b0, 1'b1});
            end
            tick();
        end
        checks++;
        if ({ser_out_valid, ser_out, tx_ready, busy} !== 4'b0010) begin
            failures++;
            $display("FAIL tx_lsb_end: valid,out,ready,busy got %b expected 0010", {ser_out_valid, ser_out, tx_ready, busy});
        end
    endtask

    task automatic test_tx_msb_first_toggle();
        logic [3:0] seq;
        seq = 4'b1101;
        tx_data = 4'b1011;
        msb_first = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            msb_first = ~msb_first;
            checks++;
            if ({ser_out_valid, ser_out} !== {1'b1, seq[i]}) begin
                failures++;
                $display("FAIL tx_msb_bit%0d: valid,out got %b expected %b", i, {ser_out_valid, ser_out}, {1'b1, seq[i]});
            end
            tick();
        end
        checks++;
        if (ser_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL tx_msb_end: ser_out_valid got %b expected 0", ser_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seq_a;
        logic [3:0] seq_b;
        seq_a = 4'b1001;
        seq_b = 4'b0110;
        msb_first = 1'b1;
        tx_data = 4'b1001;
        tx_valid = 1'b1;
        tick();
        tx_data = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ser_out_valid, ser_out, tx_ready} !== {1'b1, seq_a[i], 1'b0}) begin
                failures++;
                $display("FAIL b2b_a_bit%0d: valid,out,ready got %b expected %b", i,
                         {ser_out_valid, ser_out, tx_ready}, {1'b1, seq_a[i], 1'b0});
            end
            tick();
        end
        checks++;
        if ({ser_out_valid, tx_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_gap: valid,ready got %b expected 01", {ser_out_valid, tx_ready});
        end
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ser_out_valid, ser_out} !== {1'b1, seq_b[i]}) begin
                failures++;
                $display("FAIL b2b_b_bit%0d: valid,out got %b expected %b", i, {ser_out_valid, ser_out}, {1'b1, seq_b[i]});
            end
            tick();
        end
    endtask

    task automatic test_tx_rx_collision();
        logic [3:0] seq;
        int rx_pulses;
        seq = 4'b1001;
        rx_pulses = 0;
        tx_data = 4'b1001;
        msb_first = 1'b1;
        tx_valid = 1'b1;
        rx_start = 1'b1;
        tick();
        tx_valid = 1'b0;
        rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({ser_out_valid, ser_out} !== {1'b1, seq[i]}) begin
                failures++;
                $display("FAIL collide_bit%0d: valid,out got %b expected %b", i, {ser_out_valid, ser_out}, {1'b1, seq[i]});
            end
            if (rx_valid === 1'b1) rx_pulses++;
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            if (rx_valid === 1'b1) rx_pulses++;
            tick();
        end
        checks++;
        if (rx_pulses != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL collide_no_rx: rx pulses %0d busy %b expected 0 and 0", rx_pulses, busy);
        end
    endtask

    task automatic test_reset_mid_tx();
        int valid_cycles;
        valid_cycles = 0;
        tx_data = 4'b1111;
        msb_first = 1'b0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ser_out_valid, ser_out, busy, tx_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_tx_immediate: valid,out,busy,ready got %b expected 0000",
                     {ser_out_valid, ser_out, busy, tx_ready});
        end
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (ser_out_valid === 1'b1) valid_cycles++;
            tick();
        end
        checks++;
        if (valid_cycles != 0 || {tx_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL rst_mid_tx_after: valid cycles %0d ready,busy %b expected 0 and 10", valid_cycles, {tx_ready, busy});
        end
    endtask

`ifdef SHIFT_SEQ_RX_EN
    task automatic test_rx_msb_first();
        logic [3:0] seq;
        seq = 4'b0110;
        msb_first = 1'b1;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ser_in = seq[i];
            checks++;
            if ({busy, rx_valid} !== 2'b10) begin
                failures++;
                $display("FAIL rx_msb_shift%0d: busy,rx_valid got %b expected 10", i, {busy, rx_valid});
            end
            msb_first = ~msb_first;
            tick();
        end
        checks++;
        if ({rx_valid, rx_data} !== 5'b1_0110) begin
            failures++;
            $display("FAIL rx_msb_done: rx_valid,rx_data got %b expected 10110", {rx_valid, rx_data});
        end
        tick();
        checks++;
        if ({rx_valid, rx_data, tx_ready} !== 6'b0_0110_1) begin
            failures++;
            $display("FAIL rx_msb_hold: rx_valid,rx_data,tx_ready got %b expected 001101", {rx_valid, rx_data, tx_ready});
        end
    endtask

    task automatic test_rx_lsb_first();
        logic [3:0] seq;
        logic [3:0] expect_word;
        for (int t = 0; t < 2; t++) begin
            seq = (t == 0) ? 4'b0110 : 4'b0001;
            expect_word = (t == 0) ? 4'b0110 : 4'b0001;
            msb_first = 1'b0;
            rx_start = 1'b1;
            tick();
            rx_start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                ser_in = seq[i];
                rx_start = (i == 1);
                tick();
            end
            rx_start = 1'b0;
            checks++;
            if ({rx_valid, rx_data} !== {1'b1, expect_word}) begin
                failures++;
                $display("FAIL rx_lsb_done%0d: rx_valid,rx_data got %b expected %b", t, {rx_valid, rx_data}, {1'b1, expect_word});
            end
            tick();
            tick();
            tick();
            checks++;
            if ({busy, rx_valid} !== 2'b00) begin
                failures++;
                $display("FAIL rx_lsb_no_requeue%0d: busy,rx_valid got %b expected 00", t, {busy, rx_valid});
            end
        end
    endtask
`else
    task automatic test_rx_disabled();
        int busy_cycles;
        int rx_pulses;
        busy_cycles = 0;
        rx_pulses = 0;
        msb_first = 1'b1;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_in = i[0];
            if (busy === 1'b1) busy_cycles++;
            if (rx_valid === 1'b1) rx_pulses++;
            tick();
        end
        checks++;
        if (busy_cycles != 0 || rx_pulses != 0) begin
            failures++;
            $display("FAIL rx_disabled: busy cycles %0d rx pulses %0d expected 0 and 0", busy_cycles, rx_pulses);
        end
        checks++;
        if ({rx_data, tx_ready} !== 5'b0000_1) begin
            failures++;
            $display("FAIL rx_disabled_idle: rx_data,tx_ready got %b expected 00001", {rx_data, tx_ready});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_tx_lsb_first();
        test_tx_msb_first_toggle();
        test_back_to_back();
        test_tx_rx_collision();
        test_reset_mid_tx();
`ifdef SHIFT_SEQ_RX_EN
        test_rx_msb_first();
        test_rx_lsb_first();
`else
        test_rx_disabled();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, meaning shift word width in bits (N >= 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port tx_valid  input  1  parallel TX word offered.
REQ-005 SHALL have port tx_data  input  N  parallel TX word.
REQ-006 SHALL have port tx_ready  output  1  controller accepts TX word this cycle.
REQ-007 SHALL have port msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first; sampled at word start.
REQ-008 SHALL have port ser_out  output  1  serial TX bit.
REQ-009 SHALL have port ser_out_valid  output  1  ser_out carries a valid bit.
REQ-010 SHALL have port rx_start  input  1  single-cycle request to begin capturing one RX word.
REQ-011 SHALL have port ser_in  input  1  serial RX bit.
REQ-012 SHALL have port rx_valid  output  1  one-cycle pulse: rx_data holds a complete word.
REQ-013 SHALL have port rx_data  output  N  deserialized RX word.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, TX_SHIFT, RX_SHIFT, RX_DONE.
REQ-016 SHALL drive tx_ready = 1 only in IDLE; a TX handshake is tx_valid & tx_ready.
REQ-017 On TX handshake SHALL load tx_data into the shift register and latch msb_first on that edge, entering TX_SHIFT.
REQ-018 In TX_SHIFT SHALL assert ser_out_valid for exactly N consecutive cycles; ser_out = q[N-1] (MSB first) or q[0] (LSB first); the register shifts one bit per cycle (left or right respectively, filling with 0).
REQ-019 SHALL use a bit counter of width $clog2(N)+1, cleared on entry to each SHIFT state, and SHALL leave the SHIFT state after the cycle in which the counter equals N-1.
REQ-020 TX throughput SHALL be one word per N+1 cycles (handshake cycle, then N bit cycles); there is no back-to-back acceptance during TX_SHIFT.
REQ-021 On rx_start in IDLE SHALL latch msb_first and enter RX_SHIFT; rx_start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-022 In RX_SHIFT SHALL sample ser_in each cycle for N cycles: MSB first shifts left with ser_in entering bit 0; LSB first shifts right with ser_in entering bit N-1.
REQ-023 In RX_DONE (one cycle) SHALL assert rx_valid with rx_data = captured word, then return to IDLE.
REQ-024 rx_data SHALL hold its last captured value until the next RX_DONE.
REQ-025 If tx_valid and rx_start are both high in IDLE, TX SHALL win and rx_start SHALL be dropped.
REQ-026 msb_first changes during a word SHALL have no effect on that word.
REQ-027 ser_out and ser_out_valid SHALL be 0 outside TX_SHIFT.

Reset
REQ-028 On reset_n low SHALL immediately force IDLE, counter 0, shift register 0, rx_data 0, ser_out 0, ser_out_valid 0, rx_valid 0, busy 0, tx_ready 0 while reset_n is low and 1 after release.
REQ-029 Reset mid-word SHALL abort the word with no rx_valid pulse and no further ser_out_valid cycles.

Configuration
REQ-030 Macro SHIFT_SEQ_RX_EN SHALL compile in the RX path (RX_SHIFT, RX_DONE, rx_data register).
REQ-031 Without SHIFT_SEQ_RX_EN the ports SHALL remain, with rx_start and ser_in ignored and rx_valid and rx_data tied to 0.

Structure
REQ-032 A shared package shift_seq_pkg SHALL hold the state enum and the 2-bit datapath select encoding: HOLD = 00, SHR = 01, SHL = 10, LOAD = 11.
REQ-033 The N-bit register SHALL be a sub-module shift_seq_dp (select, msb_in, lsb_in, p_in, q) driven by this FSM; the FSM owns all sequencing.

Verification
REQ-034 N=4, LSB first, tx_data=4'b1011 handshake -> ser_out 1,1,0,1 on the next 4 cycles with ser_out_valid high, then tx_ready high.
REQ-035 N=4, MSB first, tx_data=4'b1011 -> ser_out 1,0,1,1; msb_first toggled mid-word -> no change.
REQ-036 rx_start, MSB first, ser_in 0,1,1,0 -> single rx_valid pulse one cycle after last bit with rx_data=4'b0110; LSB first with same bits -> 4'b0110 reversed = 4'b0110 check also using 1,0,0,0 -> 4'b0001.
REQ-037 tx_valid and rx_start in the same IDLE cycle -> TX word sent, no rx_valid ever.
REQ-038 reset_n low during bit 2 of TX -> ser_out_valid drops immediately; after release tx_ready=1 and busy=0.
REQ-039 Build without SHIFT_SEQ_RX_EN, pulse rx_start -> busy stays 0, rx_valid stays 0.
